// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the UART parity block.
//   par_mode_e  : parity mode encodings (unlisted codes behave as PAR_NONE)
//   has_parity  : 1 when the mode puts a parity bit on the line
//   par_expect  : parity bit for a given XOR accumulation and mode
//   len_clamp   : maps a requested data length onto 1..width
// -----------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'b000,
        PAR_EVEN  = 3'b001,
        PAR_ODD   = 3'b010,
        PAR_MARK  = 3'b011,
        PAR_SPACE = 3'b100
    } par_mode_e;

    function automatic logic has_parity(input logic [2:0] mode);
        case (par_mode_e'(mode))
            PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // acc_bit is the XOR of all counted data bits.
    function automatic logic par_expect(input logic acc_bit, input logic [2:0] mode);
        case (par_mode_e'(mode))
            PAR_EVEN: return acc_bit;
            PAR_ODD:  return ~acc_bit;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;   // space, none and reserved codes
        endcase
    endfunction

    // A length of 0, or one beyond the datapath, means "full width".
    function automatic int unsigned len_clamp(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/parity_checker.sv
// -----------------------------------------------------------------------------
// parity_checker
// RX half of the parity block: accumulates parity over incoming serial bits,
// checks the received parity bit and keeps a saturating mismatch count.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   parity_mode      : mode, sampled at rx_start
//   data_len         : data length, clamped and sampled at rx_start
//   rx_start         : begins a frame (clears accumulator and bit count)
//   rx_bit_valid     : rx_bit carries a data bit this cycle
//   rx_bit           : serial data bit
//   rx_par_valid     : rx_par_bit carries the frame's parity bit
//   rx_par_bit       : received parity bit
//   err_clr          : clears err_count (wins over a same-cycle increment)
//   par_err          : one-cycle pulse on a parity mismatch
//   err_count        : saturating mismatch count
// -----------------------------------------------------------------------------
module parity_checker
    import parity_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       parity_mode,
    input  logic [LEN_W-1:0] data_len,
    input  logic             rx_start,
    input  logic             rx_bit_valid,
    input  logic             rx_bit,
    input  logic             rx_par_valid,
    input  logic             rx_par_bit,
    input  logic             err_clr,
    output logic             par_err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       r_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_acc;
    logic             r_par_err;
    logic [CNT_W-1:0] r_err_count;

    logic [LEN_W-1:0] w_len_c;
    logic             w_mismatch;

    assign w_len_c    = LEN_W'(len_clamp(32'(data_len), WIDTH));
    // The check uses the accumulator as registered, i.e. bits from earlier cycles.
    assign w_mismatch = rx_par_valid && has_parity(r_mode)
                        && (rx_par_bit != par_expect(r_acc, r_mode));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_acc       <= 1'b0;
            r_par_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (rx_start) begin
                r_mode <= parity_mode;
                r_len  <= w_len_c;
                // A bit arriving with the start pulse is the frame's first bit.
                r_acc  <= rx_bit_valid & rx_bit;
                r_cnt  <= rx_bit_valid ? LEN_W'(1) : '0;
            end else if (rx_bit_valid && (r_cnt < r_len)) begin
                r_acc <= r_acc ^ rx_bit;
                r_cnt <= r_cnt + LEN_W'(1);
            end

            r_par_err <= w_mismatch;

            if (err_clr) begin
                r_err_count <= '0;
            end else if (w_mismatch && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign par_err   = r_par_err;
    assign err_count = r_err_count;

endmodule

// File: rtl/parity_unit.sv
// -----------------------------------------------------------------------------
// parity_unit
// UART parity block. TX: latches a frame word with its length and mode, then
// produces the parity bit one edge later. RX: delegated to parity_checker.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   busy            : serializer busy; blocks TX latching
//   data            : TX frame data, LSB-aligned
//   data_valid      : TX data present
//   data_len        : valid data bits (0 or >WIDTH means WIDTH)
//   parity_mode     : parity mode (see parity_pkg)
//   parity_bit      : generated TX parity bit
//   parity_valid    : one-cycle pulse when parity_bit is updated
//   parity_en       : latched frame carries a parity bit
//   rx_*, err_clr   : RX inputs, see parity_checker
//   par_err         : RX mismatch pulse
//   err_count       : RX saturating mismatch count
// -----------------------------------------------------------------------------
module parity_unit
    import parity_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic [WIDTH-1:0] data,
    input  logic             data_valid,
    input  logic [LEN_W-1:0] data_len,
    input  logic [2:0]       parity_mode,
    output logic             parity_bit,
    output logic             parity_valid,
    output logic             parity_en,
    input  logic             rx_start,
    input  logic             rx_bit_valid,
    input  logic             rx_bit,
    input  logic             rx_par_valid,
    input  logic             rx_par_bit,
    input  logic             err_clr,
    output logic             par_err,
    output logic [CNT_W-1:0] err_count
);

    logic [WIDTH-1:0] r_data;
    logic [LEN_W-1:0] r_len;
    logic [2:0]       r_mode;
    logic             r_pend;
    logic             r_parity_bit;
    logic             r_parity_valid;
    logic             r_parity_en;

    logic             w_accept;
    logic [LEN_W-1:0] w_len_c;
    logic [WIDTH-1:0] w_masked;

    assign w_accept = data_valid & ~busy;
    assign w_len_c  = LEN_W'(len_clamp(32'(data_len), WIDTH));

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(r_len)) begin
                w_masked[i] = r_data[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    // NOTE: reset is asynchronous active-low; all TX state, including the
    // pending flag, is cleared so an in-flight frame is abandoned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data         <= '0;
            r_len          <= '0;
            r_mode         <= '0;
            r_pend         <= 1'b0;
            r_parity_bit   <= 1'b0;
            r_parity_valid <= 1'b0;
            r_parity_en    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= data;
                r_len  <= w_len_c;
                r_mode <= parity_mode;
            end
            r_pend <= w_accept;

            // Compute from the latched copy, so later input changes cannot
            // disturb a frame already accepted.
            if (r_pend) begin
                r_parity_bit <= par_expect(^w_masked, r_mode);
                r_parity_en  <= has_parity(r_mode);
            end
            r_parity_valid <= r_pend;
        end
    end

    assign parity_bit   = r_parity_bit;
    assign parity_valid = r_parity_valid;
    assign parity_en    = r_parity_en;

    parity_checker #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk          (clk),
        .rst          (rst),
        .parity_mode  (parity_mode),
        .data_len     (data_len),
        .rx_start     (rx_start),
        .rx_bit_valid (rx_bit_valid),
        .rx_bit       (rx_bit),
        .rx_par_valid (rx_par_valid),
        .rx_par_bit   (rx_par_bit),
        .err_clr      (err_clr),
        .par_err      (par_err),
        .err_count    (err_count)
    );

endmodule

// File: doc/parity_unit.md
Name: parity_unit

Overview:
- Next-generation parity block for the UART datapath.
- TX side: latches a frame word plus its configuration, then generates the parity bit for the serializer.
- Supports runtime data length and five parity modes.
- RX side: accumulates parity over received serial bits, checks the received parity bit, and keeps a saturating error count.

Parameters:
- WIDTH, 8: maximum data bits per frame.
- LEN_W, 4: width of data_len; must hold the value WIDTH.
- CNT_W, 8: width of the parity error counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- busy, input, 1: serializer busy; blocks TX latching.
- data, input, WIDTH: TX frame data, LSB-aligned.
- data_valid, input, 1: TX data-present strobe.
- data_len, input, LEN_W: number of valid data bits.
- parity_mode, input, 3: 000 none, 001 even, 010 odd, 011 mark, 100 space; other codes are treated as none.
- parity_bit, output, 1: generated TX parity bit.
- parity_valid, output, 1: one-cycle pulse; parity_bit is updated.
- parity_en, output, 1: latched frame carries a parity bit.
- rx_start, input, 1: start of RX frame; clears the accumulator and samples parity_mode and data_len.
- rx_bit_valid, input, 1: an RX data bit is present.
- rx_bit, input, 1: RX data bit.
- rx_par_valid, input, 1: the received parity bit is present.
- rx_par_bit, input, 1: received parity bit.
- err_clr, input, 1: clears err_count.
- par_err, output, 1: one-cycle pulse on parity mismatch.
- err_count, output, CNT_W: saturating mismatch count.

Behaviour:
- Reset (rst low, asynchronous): every register and output is cleared to 0, including the latched data/len/mode, parity_bit, parity_valid, parity_en, par_err and err_count. Any pending operation is abandoned.
- Effective length: 0 or any value above WIDTH clamps to WIDTH.
- mask = low len bits set; masked = data AND mask.
- TX accept: at an edge where data_valid=1 and busy=0, latch data, clamped len and mode (edge N). When busy=1, data_valid is ignored and all TX registers hold.
- TX compute, edge N+1:
  - parity_bit: even = XOR(masked); odd = XNOR(masked); mark = 1; space = 0; none = 0.
  - parity_en = 1 unless mode is none.
  - parity_valid = 1 for exactly the cycle following edge N+1.
- TX latency: 2 edges from accept to parity_bit. Back-to-back accepts are allowed and each produces its own pulse.
- TX hold: mode, data or len changes after the latch do not affect the pending result. parity_bit and parity_en hold until the next compute.
- RX accumulator: acc (1 bit) and bit count cnt (LEN_W bits). Mode and len are sampled at rx_start.
  - rx_start clears acc and cnt.
  - rx_start together with rx_bit_valid in the same cycle: the clear is applied, then that bit counts as the first bit (acc = rx_bit, cnt = 1).
  - rx_bit_valid with cnt below the sampled len: acc ^= rx_bit, cnt++.
  - Bits arriving after cnt reaches len are ignored; cnt saturates at len.
- RX check, on rx_par_valid:
  - expected parity follows the TX rule, applied to acc and the sampled mode.
  - If mode is not none and rx_par_bit != expected: par_err pulses 1 cycle (registered, the edge after rx_par_valid) and err_count increments.
  - Mode none: rx_par_valid is ignored.
  - A check does not clear acc; only rx_start does.
- Counter: saturates at 2^CNT_W-1.
  - err_clr has priority over an increment in the same cycle; count becomes 0.
  - par_err still pulses when err_clr and a mismatch coincide.
- TX and RX paths are fully independent and may operate in the same cycle.

Decomposition:
- Package parity_pkg holds:
  - mode encodings: PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE;
  - function par_expect(acc_bit, mode), shared by the TX and RX paths;
  - function len_clamp(len).
- Sub-module parity_checker holds the RX accumulator, check logic and counter. The top level holds the TX latch/compute and instantiates parity_checker.

Test Plan:
- data=8'hA5, len=8, even, data_valid=1, busy=0 -> 2 edges later parity_bit=0, parity_valid pulse, parity_en=1. Repeat with odd -> parity_bit=1.
- data=8'hFF, len=5, even -> masked 5'h1F has 5 ones, parity_bit=1. len=0 clamps to 8 -> parity_bit=0. len=12 clamps to 8 -> parity_bit=0.
- Accept 8'h01 with even parity (parity_bit=1). Then busy=1, data_valid=1, data=8'h03 -> no parity_valid pulse, parity_bit stays 1. Change mode to odd one cycle after accept -> result still even.
- Mark -> parity_bit=1; space -> 0; none -> parity_bit=0, parity_en=0. Mode code 3'b111 behaves as none.
- RX, even, len=8: rx_start, bits 1,0,1,1,0,0,0,0, rx_par_bit=0 -> expected 1, par_err pulse, err_count=1. rx_par_bit=1 -> no error. 300 mismatches -> err_count=255. err_clr coincident with a mismatch -> err_count=0 and par_err pulses.
- rst low for 1 cycle in the cycle after a TX accept -> no parity_valid pulse, all outputs 0. The next accept after rst release produces a correct result.
